// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states, data width.
package lsu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane handling: extracts and extends a byte/half for loads, merges a byte/half into a word for stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      offset,
  input  size_e           size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = word[{offset, 3'b000} +: 8];
    lane_h     = offset[1] ? word[31:16] : word[15:0];
    load_data  = word;
    store_data = wdata;
    case (size)
      SIZE_B: begin
        load_data  = {{24{~is_unsigned & lane_b[7]}}, lane_b};
        store_data = word;
        store_data[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_H: begin
        load_data  = {{16{~is_unsigned & lane_h[15]}}, lane_h};
        store_data = offset[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      end
      default: begin
        load_data  = word;
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging a core request/response port to a single-port word memory.
// Optional LSU_BOUNDS_CHECK_EN flags word indices >= MEM_WORDS as errors.
//
// state   | meaning
// IDLE    | ready for a request
// RD      | memory read strobe, word captured at end of cycle
// WR      | single memory write strobe
// RESP    | response held until rsp_ready
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 200,
  parameter int IDX_W     = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_write_enable,
  output logic            mem_read_enable,
  input  logic [XLEN-1:0] mem_read_data
);

  state_e           state_q, state_d;
  logic             we_q, uns_q, err_q;
  size_e            size_q;
  logic [IDX_W+1:0] addr_q;
  logic [XLEN-1:0]  wdata_q, word_q;
  logic             req_err;
  logic [XLEN-1:0]  load_data, store_data;
  logic             unused_addr;

  assign unused_addr = &{1'b0, req_addr[XLEN-1:IDX_W+2]};

  always_comb begin
    case (size_e'(req_size))
      SIZE_H:  req_err = req_addr[0];
      SIZE_W:  req_err = |req_addr[1:0];
      SIZE_X:  req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
`ifdef LSU_BOUNDS_CHECK_EN
    if ({{(XLEN-IDX_W){1'b0}}, req_addr[IDX_W+1:2]} >= XLEN'(MEM_WORDS)) req_err = 1'b1;
`endif
  end

`ifndef LSU_BOUNDS_CHECK_EN
  logic unused_mem_words;
  assign unused_mem_words = (MEM_WORDS != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SIZE_B;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && req_valid) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= req_err;
        size_q  <= size_e'(req_size);
        addr_q  <= req_addr[IDX_W+1:0];
        wdata_q <= req_wdata;
      end
      if (state_q == ST_RD) word_q <= mem_read_data;
    end
  end

  // Sub-word stores read the word first so untouched lanes are written back unchanged.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err)                             state_d = ST_RESP;
          else if (req_we && req_size == SIZE_W)   state_d = ST_WR;
          else                                     state_d = ST_RD;
        end
      end
      ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  lsu_align u_align (
    .word        (word_q),
    .wdata       (wdata_q),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  // Outputs are gated by rst_n so an asserted reset suppresses a pending write strobe at once.
  always_comb begin
    req_ready        = rst_n && state_q == ST_IDLE;
    rsp_valid        = rst_n && state_q == ST_RESP;
    rsp_err          = rsp_valid && err_q;
    rsp_rdata        = (rsp_valid && !we_q && !err_q) ? load_data : '0;
    mem_read_enable  = rst_n && state_q == ST_RD;
    mem_write_enable = rst_n && state_q == ST_WR;
    mem_address      = (mem_read_enable || mem_write_enable) ?
                       {{(XLEN-IDX_W){1'b0}}, addr_q[IDX_W+1:2]} : '0;
    mem_write_data   = mem_write_enable ? store_data : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases, randomized traffic against an array model.
module tb_load_store_unit;

  localparam int MEM_WORDS = 200;
  localparam int IDX_W     = 12;
  localparam int DEPTH     = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int checks = 0;
  int passes = 0;

  int          ob_rsp, ob_wr, ob_rd, ob_wr_cyc;
  logic [31:0] ob_rdata, ob_addr;
  logic        ob_err;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_address[IDX_W-1:0]];
  always @(posedge clk) if (mem_write_enable) mem[mem_address[IDX_W-1:0]] <= mem_write_data;

  // ---- reference model: plain arithmetic on byte addresses ----
  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    logic e;
    e = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
`ifdef LSU_BOUNDS_CHECK_EN
    if (widx(addr) >= MEM_WORDS) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
    int unsigned sh, v;
    sh = (addr % 4) * 8;
    if (size == 2'd0) begin
      v = (w >> sh) & 32'hFF;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] addr,
                                              input logic [1:0] size, input logic [31:0] wd);
    int unsigned sh, mask;
    sh = (addr % 4) * 8;
    if (size == 2'd0)      mask = 32'hFF << sh;
    else if (size == 2'd1) mask = 32'hFFFF << sh;
    else                   mask = 32'hFFFF_FFFF;
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic poke(input int idx, input logic [31:0] v);
    mem[idx]     = v;
    ref_mem[idx] = v;
  endtask

  // Issues one request and records what the DUT did on each following cycle.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    ob_rsp = -1; ob_wr = 0; ob_rd = 0; ob_wr_cyc = -1;
    ob_rdata = 'x; ob_err = 1'bx; ob_addr = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_write_enable) begin ob_wr++; ob_wr_cyc = k; ob_addr = mem_address; end
      if (mem_read_enable)  begin ob_rd++; ob_addr = mem_address; end
      if (rsp_valid) begin
        ob_rsp = k; ob_rdata = rsp_rdata; ob_err = rsp_err;
        break;
      end
    end
    @(posedge clk); #1;
    if (ob_rsp < 0) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready); else passes++;
    checks++;
    if ({rsp_valid, rsp_err, mem_write_enable, mem_read_enable} !== 4'b0 ||
        rsp_rdata !== 0 || mem_address !== 0 || mem_write_data !== 0)
      $display("FAIL reset_outputs: got v%b e%b we%b re%b rd%h a%h wd%h want all 0",
               rsp_valid, rsp_err, mem_write_enable, mem_read_enable, rsp_rdata, mem_address, mem_write_data);
    else passes++;
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", req_ready); else passes++;
    checks++; if (mem[4] !== ref_mem[4]) $display("FAIL reset_no_write: got %h want %h", mem[4], ref_mem[4]); else passes++;
  endtask

  task automatic test_word_access();
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    ref_mem[4] = 32'hDEAD_BEEF;
    checks++; if (ob_rsp !== 2) $display("FAIL st_word_lat: got %0d want 2", ob_rsp); else passes++;
    checks++; if (ob_wr !== 1 || ob_wr_cyc !== 1) $display("FAIL st_word_strobe: got cnt %0d cyc %0d want 1 1", ob_wr, ob_wr_cyc); else passes++;
    checks++; if (mem[4] !== 32'hDEAD_BEEF) $display("FAIL st_word_mem: got %h want deadbeef", mem[4]); else passes++;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    checks++; if (ob_rsp !== 2 || ob_wr !== 0) $display("FAIL ld_word_lat: got lat %0d wr %0d want 2 0", ob_rsp, ob_wr); else passes++;
    checks++; if (ob_rdata !== 32'hDEAD_BEEF || ob_err !== 1'b0) $display("FAIL ld_word_data: got %h err %b want deadbeef 0", ob_rdata, ob_err); else passes++;
  endtask

  task automatic test_subword_load();
    poke(4, 32'h1122_3344);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    checks++; if (ob_rdata !== 32'h0000_0011) $display("FAIL ld_byte: got %h want 00000011", ob_rdata); else passes++;
    poke(4, 32'h80FF_0000);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    checks++; if (ob_rdata !== 32'hFFFF_80FF) $display("FAIL ld_half_s: got %h want ffff80ff", ob_rdata); else passes++;
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    checks++; if (ob_rdata !== 32'h0000_80FF) $display("FAIL ld_half_u: got %h want 000080ff", ob_rdata); else passes++;
  endtask

  task automatic test_rmw_store();
    poke(4, 32'h1122_3344);
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB);
    checks++; if (mem[4] !== 32'h1122_AB44) $display("FAIL st_byte_mem: got %h want 1122ab44", mem[4]); else passes++;
    checks++; if (ob_rsp !== 3 || ob_wr_cyc !== 2 || ob_rd !== 1) $display("FAIL st_byte_timing: got rsp %0d wr %0d rd %0d want 3 2 1", ob_rsp, ob_wr_cyc, ob_rd); else passes++;
    checks++; if (ob_rdata !== 32'h0) $display("FAIL st_byte_rdata: got %h want 0", ob_rdata); else passes++;
    ref_mem[4] = 32'h1122_AB44;
  endtask

  task automatic test_errors();
    issue(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
    checks++; if (ob_err !== 1'b1 || ob_rsp !== 1) $display("FAIL err_misalign: got err %b lat %0d want 1 1", ob_err, ob_rsp); else passes++;
    checks++; if (ob_rd !== 0 || ob_wr !== 0) $display("FAIL err_misalign_strobe: got rd %0d wr %0d want 0 0", ob_rd, ob_wr); else passes++;
    issue(1'b1, 2'd3, 1'b0, 32'h20, 32'h5555_AAAA);
    checks++; if (ob_err !== 1'b1 || ob_rsp !== 1 || ob_wr !== 0) $display("FAIL err_size: got err %b lat %0d wr %0d want 1 1 0", ob_err, ob_rsp, ob_wr); else passes++;
    checks++; if (mem[8] !== ref_mem[8]) $display("FAIL err_size_mem: got %h want %h", mem[8], ref_mem[8]); else passes++;
    issue(1'b0, 2'd2, 1'b0, 32'h320, 32'h0);
`ifdef LSU_BOUNDS_CHECK_EN
    checks++; if (ob_err !== 1'b1 || ob_rsp !== 1 || ob_rd !== 0) $display("FAIL err_bounds: got err %b lat %0d rd %0d want 1 1 0", ob_err, ob_rsp, ob_rd); else passes++;
`else
    checks++; if (ob_err !== 1'b0 || ob_rdata !== ref_mem[200]) $display("FAIL no_bounds: got err %b data %h want 0 %h", ob_err, ob_rdata, ref_mem[200]); else passes++;
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic        we, uns, e;
      logic [1:0]  size;
      logic [31:0] addr, wd, exp_data;
      int          idx, exp_lat;
      we   = $urandom_range(0, 1);
      uns  = $urandom_range(0, 1);
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFF_C000);
      wd   = $urandom;
      idx  = widx(addr);
      e    = model_err(size, addr);
      exp_data = 32'h0;
      if (e)                      exp_lat = 1;
      else if (!we)               exp_lat = 2;
      else if (size == 2'd2)      exp_lat = 2;
      else                        exp_lat = 3;
      if (!e && !we) exp_data = model_load(ref_mem[idx], addr, size, uns);
      if (!e && we)  ref_mem[idx] = model_store(ref_mem[idx], addr, size, wd);
      issue(we, size, uns, addr, wd);
      checks++; if (ob_err !== e || ob_rsp !== exp_lat) $display("FAIL rnd_resp[%0d]: got err %b lat %0d want %b %0d", n, ob_err, ob_rsp, e, exp_lat); else passes++;
      checks++; if (ob_rdata !== exp_data) $display("FAIL rnd_rdata[%0d]: got %h want %h", n, ob_rdata, exp_data); else passes++;
      checks++; if (ob_wr !== ((we && !e) ? 1 : 0)) $display("FAIL rnd_wr_count[%0d]: got %0d want %0d", n, ob_wr, (we && !e) ? 1 : 0); else passes++;
      checks++; if (mem[idx] !== ref_mem[idx]) $display("FAIL rnd_mem[%0d]: got %h want %h", n, mem[idx], ref_mem[idx]); else passes++;
      if (!e) begin
        checks++; if (ob_addr !== 32'(idx)) $display("FAIL rnd_addr[%0d]: got %h want %h", n, ob_addr, idx); else passes++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    poke(7, 32'hCAFE_F00D);
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h1C; req_wdata = 0;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    @(negedge clk);
    held = rsp_rdata;
    checks++; if (rsp_valid !== 1'b1 || held !== 32'hCAFE_F00D) $display("FAIL bp_first: got v%b %h want 1 cafef00d", rsp_valid, held); else passes++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || req_ready !== 1'b0)
        $display("FAIL bp_hold[%0d]: got v%b %h rdy%b want 1 cafef00d 0", k, rsp_valid, rsp_rdata, req_ready);
      else passes++;
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL bp_release: got v%b rdy%b want 0 1", rsp_valid, req_ready); else passes++;
    checks++; if (mem[16] !== ref_mem[16]) $display("FAIL bp_ignored_req: got %h want %h", mem[16], ref_mem[16]); else passes++;
  endtask

  task automatic test_reset_mid_rmw();
    poke(9, 32'h1122_3344);
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h25; req_wdata = 32'hAB;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_write_enable !== 1'b1) $display("FAIL rmw_in_wr: got we %b want 1", mem_write_enable); else passes++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_write_enable, mem_read_enable, rsp_valid, rsp_err, req_ready} !== 5'b0 ||
        mem_address !== 0 || mem_write_data !== 0 || rsp_rdata !== 0)
      $display("FAIL rmw_reset_outputs: got we%b re%b v%b e%b rdy%b a%h wd%h rd%h want all 0",
               mem_write_enable, mem_read_enable, rsp_valid, rsp_err, req_ready, mem_address, mem_write_data, rsp_rdata);
    else passes++;
    @(posedge clk);
    @(negedge clk);
    checks++; if (mem[9] !== 32'h1122_3344) $display("FAIL rmw_reset_mem: got %h want 11223344", mem[9]); else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL rmw_reset_after: got v%b rdy%b want 0 1", rsp_valid, req_ready); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (mem[9] !== 32'h1122_3344) $display("FAIL rmw_reset_late: got %h want 11223344", mem[9]); else passes++;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_word_access();
    test_subword_load();
    test_rmw_store();
    test_errors();
    test_random();
    test_backpressure();
    test_reset_mid_rmw();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
